// File: rtl/gravacao_pkg.sv
// Shared types and constants for the gravacao recorder/player slice.
package gravacao_pkg;

  localparam int GRAV_DATA_W = 8;
  localparam int GRAV_ADDR_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LOAD    = 3'd2,
    PRESENT = 3'd3,
    PACE    = 3'd4
  } player_state_t;

endpackage

// File: rtl/gravacao_if.sv
// Sample-memory read port plus valid/ready playback stream of the player.
interface gravacao_if
  import gravacao_pkg::*;
#(
  parameter int ADDR_W = GRAV_ADDR_W,
  parameter int DATA_W = GRAV_DATA_W
) ();

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mem_rd, mem_addr, out_data, out_valid,
    input  mem_data, out_ready
  );

  modport slave (
    input  mem_rd, mem_addr, out_data, out_valid,
    output mem_data, out_ready
  );

endinterface

// File: rtl/gravacao_pace_counter.sv
// Loadable down-counter pacing the gap between an accepted byte and the next fetch.
module gravacao_pace_counter
  import gravacao_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Remaining pace cycles, including the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= value;
    end else if (en && (count_r != {W{1'b0}})) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // High in the last pace cycle: the count reaches 0 at the coming edge.
  assign zero = (count_r <= W'(1));

endmodule

// File: rtl/gravacao_player.sv
// Playback reader: streams LENGTH bytes from sample memory address 0 upward.
// Optional PLAYER_LOOP_EN: a latched loop=1 repeats the pass until stop/rst.
module gravacao_player
  import gravacao_pkg::*;
#(
  parameter int ADDR_W     = GRAV_ADDR_W,
  parameter int DATA_W     = GRAV_DATA_W,
  parameter int RATE_DIV_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADDR_W-1:0]     length,
  input  logic [RATE_DIV_W-1:0] rate_div,
  input  logic                  loop,
  gravacao_if.master            bus,
  output logic                  busy,
  output logic                  done
);

`ifdef PLAYER_LOOP_EN
  localparam logic LOOP_EN = 1'b1;
`else
  localparam logic LOOP_EN = 1'b0;
`endif

  player_state_t         state_r, state_nxt_s;
  logic [ADDR_W-1:0]     idx_r, idx_nxt_s, len_r;
  logic [RATE_DIV_W-1:0] rate_r;
  logic                  loop_r;
  logic                  latch_s, done_nxt_s, pace_load_s, pace_zero_s;
  logic                  handshake_s, last_s, repeat_s;
  logic                  mem_rd_r, out_valid_r, done_r;
  logic [ADDR_W-1:0]     mem_addr_r;
  logic [DATA_W-1:0]     out_data_r;

  assign handshake_s = out_valid_r & bus.out_ready;
  assign last_s      = (idx_r == (len_r - ADDR_W'(1)));
  assign repeat_s    = loop_r & LOOP_EN;

  gravacao_pace_counter #(.W(RATE_DIV_W)) u_pace (
    .clk  (clk),
    .rst  (rst),
    .load (pace_load_s),
    .en   (state_r == PACE),
    .value(rate_r),
    .zero (pace_zero_s)
  );

  // Next-state and per-transition control decode; stop overrides everything.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    latch_s     = 1'b0;
    done_nxt_s  = 1'b0;
    pace_load_s = 1'b0;
    if (stop) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            if (length != {ADDR_W{1'b0}}) begin
              state_nxt_s = FETCH;
              latch_s     = 1'b1;
              idx_nxt_s   = {ADDR_W{1'b0}};
            end else begin
              done_nxt_s = 1'b1;
            end
          end else begin
            state_nxt_s = IDLE;
          end
        end
        FETCH:   state_nxt_s = LOAD;
        LOAD:    state_nxt_s = PRESENT;
        PRESENT: begin
          if (handshake_s) begin
            done_nxt_s = last_s;
            if (last_s && !repeat_s) begin
              state_nxt_s = IDLE;
            end else begin
              idx_nxt_s = last_s ? {ADDR_W{1'b0}} : (idx_r + ADDR_W'(1));
              if (rate_r != {RATE_DIV_W{1'b0}}) begin
                state_nxt_s = PACE;
                pace_load_s = 1'b1;
              end else begin
                state_nxt_s = FETCH;
              end
            end
          end else begin
            state_nxt_s = PRESENT;
          end
        end
        PACE: begin
          if (pace_zero_s) begin
            state_nxt_s = FETCH;
          end else begin
            state_nxt_s = PACE;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State, byte index and start-time configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= {ADDR_W{1'b0}};
      len_r   <= {ADDR_W{1'b0}};
      rate_r  <= {RATE_DIV_W{1'b0}};
      loop_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      if (latch_s) begin
        len_r  <= length;
        rate_r <= rate_div;
        loop_r <= loop;
      end
    end
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      out_data_r  <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      mem_rd_r    <= (state_nxt_s == FETCH);
      out_valid_r <= (state_nxt_s == PRESENT);
      done_r      <= done_nxt_s;
      if (state_nxt_s == FETCH) begin
        mem_addr_r <= idx_nxt_s;
      end
      // A read in flight is dropped when stop pulls LOAD back to IDLE.
      if ((state_r == LOAD) && (state_nxt_s == PRESENT)) begin
        out_data_r <= bus.mem_data;
      end
    end
  end

  assign bus.mem_rd    = mem_rd_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign done          = done_r;
  assign busy          = (state_r != IDLE);

endmodule

// File: tb/tb_gravacao_player.sv
// Directed self-checking bench for gravacao_player; expectations follow PLAYER_LOOP_EN.
module tb_gravacao_player;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] length = 8'd0;
  logic [7:0] rate_div = 8'd0;
  logic       loop = 1'b0;
  logic       busy, done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t0 = 0;

  logic [7:0] mem [256];
  logic [7:0] acc_data [$];
  int         acc_cyc [$];
  logic [7:0] rd_addr [$];
  int         rd_cyc [$];
  int         done_cyc [$];

  gravacao_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  gravacao_player #(.ADDR_W(8), .DATA_W(8), .RATE_DIV_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .length(length),
    .rate_div(rate_div), .loop(loop), .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sample memory with one cycle of read latency.
  always @(posedge clk) if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];

  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      acc_data.push_back(bus.out_data);
      acc_cyc.push_back(cyc);
    end
    if (bus.mem_rd) begin
      rd_addr.push_back(bus.mem_addr);
      rd_cyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    acc_data.delete(); acc_cyc.delete(); rd_addr.delete(); rd_cyc.delete(); done_cyc.delete();
  endtask

  task automatic kick(input logic [7:0] len, input logic [7:0] rd, input logic lp);
    length = len; rate_div = rd; loop = lp;
    start = 1'b1; t0 = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_cmp++; if (bus.mem_rd !== 1'b0) begin n_err++; $display("FAIL reset_mem_rd got %0h exp 0", bus.mem_rd); end
    n_cmp++; if (bus.mem_addr !== 8'h00) begin n_err++; $display("FAIL reset_mem_addr got %0h exp 0", bus.mem_addr); end
    n_cmp++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data got %0h exp 0", bus.out_data); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0h exp 0", bus.out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0h exp 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %0h exp 0", done); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int       e_rd [4]  = '{1, 4, 7, 10};
    int       e_acc [4] = '{3, 6, 9, 12};
    logic [7:0] e_dat [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    clear_mon();
    kick(8'd4, 8'd0, 1'b0);
    while (cyc - t0 < 16) step();
    n_cmp++; if (rd_cyc.size() !== 4) begin n_err++; $display("FAIL basic_rd_count got %0d exp 4", rd_cyc.size()); end
    n_cmp++; if (acc_cyc.size() !== 4) begin n_err++; $display("FAIL basic_acc_count got %0d exp 4", acc_cyc.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= rd_cyc.size() || rd_cyc[i] - t0 !== e_rd[i] || rd_addr[i] !== 8'(i)) begin
        n_err++; $display("FAIL basic_rd[%0d] got cyc %0d addr %0h exp cyc %0d addr %0h", i,
                          (i < rd_cyc.size()) ? rd_cyc[i] - t0 : -1, (i < rd_addr.size()) ? rd_addr[i] : 8'hxx, e_rd[i], i);
      end
      n_cmp++;
      if (i >= acc_cyc.size() || acc_cyc[i] - t0 !== e_acc[i] || acc_data[i] !== e_dat[i]) begin
        n_err++; $display("FAIL basic_out[%0d] got cyc %0d data %0h exp cyc %0d data %0h", i,
                          (i < acc_cyc.size()) ? acc_cyc[i] - t0 : -1, (i < acc_data.size()) ? acc_data[i] : 8'hxx, e_acc[i], e_dat[i]);
      end
    end
    n_cmp++; if (done_cyc.size() !== 1 || done_cyc[0] - t0 !== 13) begin n_err++; $display("FAIL basic_done got n=%0d exp one pulse at 13", done_cyc.size()); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after got %0h exp 0", busy); end
  endtask

  task automatic test_backpressure();
    int       e_rd [4]  = '{1, 4, 12, 15};
    int       e_acc [4] = '{3, 11, 14, 17};
    logic [7:0] e_dat [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    int rel;
    clear_mon();
    kick(8'd4, 8'd0, 1'b0);
    while (cyc - t0 < 20) begin
      step();
      rel = cyc - t0;
      if (rel >= 7 && rel <= 11) begin
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11 || bus.mem_rd !== 1'b0) begin
          n_err++; $display("FAIL bp_hold@%0d got valid %0h data %0h rd %0h exp 1 11 0", rel, bus.out_valid, bus.out_data, bus.mem_rd);
        end
      end
      if (rel == 6) bus.out_ready = 1'b0;
      if (rel == 11) bus.out_ready = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= rd_cyc.size() || rd_cyc[i] - t0 !== e_rd[i] || rd_addr[i] !== 8'(i)) begin
        n_err++; $display("FAIL bp_rd[%0d] got cyc %0d exp cyc %0d", i, (i < rd_cyc.size()) ? rd_cyc[i] - t0 : -1, e_rd[i]);
      end
      n_cmp++;
      if (i >= acc_cyc.size() || acc_cyc[i] - t0 !== e_acc[i] || acc_data[i] !== e_dat[i]) begin
        n_err++; $display("FAIL bp_out[%0d] got cyc %0d data %0h exp cyc %0d data %0h", i,
                          (i < acc_cyc.size()) ? acc_cyc[i] - t0 : -1, (i < acc_data.size()) ? acc_data[i] : 8'hxx, e_acc[i], e_dat[i]);
      end
    end
    n_cmp++; if (done_cyc.size() !== 1 || done_cyc[0] - t0 !== 18) begin n_err++; $display("FAIL bp_done got n=%0d exp one pulse at 18", done_cyc.size()); end
  endtask

  task automatic test_pace();
    int       e_rd [3]  = '{1, 6, 11};
    int       e_acc [3] = '{3, 8, 13};
    int rel;
    clear_mon();
    kick(8'd3, 8'd2, 1'b0);
    while (cyc - t0 < 17) begin
      step();
      rel = cyc - t0;
      if (rel == 2) begin start = 1'b1; length = 8'd7; rate_div = 8'd0; end
      if (rel == 3) start = 1'b0;
    end
    n_cmp++; if (rd_cyc.size() !== 3) begin n_err++; $display("FAIL pace_rd_count got %0d exp 3", rd_cyc.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (i >= rd_cyc.size() || rd_cyc[i] - t0 !== e_rd[i] || rd_addr[i] !== 8'(i)) begin
        n_err++; $display("FAIL pace_rd[%0d] got cyc %0d exp cyc %0d", i, (i < rd_cyc.size()) ? rd_cyc[i] - t0 : -1, e_rd[i]);
      end
      n_cmp++;
      if (i >= acc_cyc.size() || acc_cyc[i] - t0 !== e_acc[i] || acc_data[i] !== 8'(8'h10 + i)) begin
        n_err++; $display("FAIL pace_out[%0d] got cyc %0d exp cyc %0d", i, (i < acc_cyc.size()) ? acc_cyc[i] - t0 : -1, e_acc[i]);
      end
    end
    n_cmp++; if (done_cyc.size() !== 1 || done_cyc[0] - t0 !== 14) begin n_err++; $display("FAIL pace_done got n=%0d exp one pulse at 14", done_cyc.size()); end
    length = 8'd0; rate_div = 8'd0;
  endtask

  task automatic test_zero_length();
    clear_mon();
    kick(8'd0, 8'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy@%0d got %0h exp 0", i, busy); end
      step();
    end
    n_cmp++; if (done_cyc.size() !== 1 || done_cyc[0] - t0 !== 1) begin n_err++; $display("FAIL zero_done got n=%0d exp one pulse at 1", done_cyc.size()); end
    n_cmp++; if (rd_cyc.size() !== 0) begin n_err++; $display("FAIL zero_rd got %0d reads exp 0", rd_cyc.size()); end
  endtask

  task automatic test_stop();
    int rel;
    clear_mon();
    kick(8'd4, 8'd0, 1'b0);
    while (cyc - t0 < 15) begin
      step();
      rel = cyc - t0;
      if (rel == 6) bus.out_ready = 1'b0;
      if (rel == 7) begin
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11) begin n_err++; $display("FAIL stop_pre got valid %0h data %0h exp 1 11", bus.out_valid, bus.out_data); end
        stop = 1'b1;
      end
      if (rel == 8) begin
        stop = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL stop_valid got %0h exp 0", bus.out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stop_busy got %0h exp 0", busy); end
        bus.out_ready = 1'b1;
      end
    end
    n_cmp++; if (done_cyc.size() !== 0) begin n_err++; $display("FAIL stop_done got %0d pulses exp 0", done_cyc.size()); end
    n_cmp++; if (acc_cyc.size() !== 1 || rd_cyc.size() !== 2) begin n_err++; $display("FAIL stop_activity got acc %0d rd %0d exp 1 2", acc_cyc.size(), rd_cyc.size()); end
  endtask

  task automatic test_start_stop_idle();
    clear_mon();
    stop = 1'b1;
    kick(8'd4, 8'd0, 1'b0);
    stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ss_busy@%0d got %0h exp 0", i, busy); end
      step();
    end
    n_cmp++; if (rd_cyc.size() !== 0 || done_cyc.size() !== 0) begin n_err++; $display("FAIL ss_activity got rd %0d done %0d exp 0 0", rd_cyc.size(), done_cyc.size()); end
  endtask

  task automatic test_reset_mid_fetch();
    clear_mon();
    kick(8'd4, 8'd0, 1'b0);
    while (cyc - t0 < 4) step();
    n_cmp++; if (bus.mem_rd !== 1'b1 || bus.out_data !== 8'h10) begin n_err++; $display("FAIL rstmid_pre got rd %0h data %0h exp 1 10", bus.mem_rd, bus.out_data); end
    rst = 1'b1;
    step();
    n_cmp++; if (bus.mem_rd !== 1'b0 || bus.mem_addr !== 8'h00) begin n_err++; $display("FAIL rstmid_mem got rd %0h addr %0h exp 0 0", bus.mem_rd, bus.mem_addr); end
    n_cmp++; if (bus.out_data !== 8'h00 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out got data %0h valid %0h exp 0 0", bus.out_data, bus.out_valid); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rstmid_status got busy %0h done %0h exp 0 0", busy, done); end
    rst = 1'b0;
    step(); step(); step();
    n_cmp++; if (rd_cyc.size() !== 2 || busy !== 1'b0) begin n_err++; $display("FAIL rstmid_after got rd %0d busy %0h exp 2 0", rd_cyc.size(), busy); end
  endtask

  task automatic test_loop();
`ifdef PLAYER_LOOP_EN
    int       e_acc [4] = '{3, 6, 9, 12};
    logic [7:0] e_dat [4] = '{8'h10, 8'h11, 8'h10, 8'h11};
    int       e_done [2] = '{7, 13};
    logic     e_busy = 1'b1;
`else
    int       e_acc [2] = '{3, 6};
    logic [7:0] e_dat [2] = '{8'h10, 8'h11};
    int       e_done [1] = '{7};
    logic     e_busy = 1'b0;
`endif
    int n_done;
    clear_mon();
    kick(8'd2, 8'd0, 1'b1);
    loop = 1'b0;
    while (cyc - t0 < 14) step();
    n_cmp++; if (busy !== e_busy) begin n_err++; $display("FAIL loop_busy got %0h exp %0h", busy, e_busy); end
    n_cmp++; if (acc_cyc.size() !== $size(e_acc)) begin n_err++; $display("FAIL loop_acc_count got %0d exp %0d", acc_cyc.size(), $size(e_acc)); end
    for (int i = 0; i < $size(e_acc); i++) begin
      n_cmp++;
      if (i >= acc_cyc.size() || acc_cyc[i] - t0 !== e_acc[i] || acc_data[i] !== e_dat[i]) begin
        n_err++; $display("FAIL loop_out[%0d] got cyc %0d exp cyc %0d data %0h", i, (i < acc_cyc.size()) ? acc_cyc[i] - t0 : -1, e_acc[i], e_dat[i]);
      end
    end
    n_cmp++; if (done_cyc.size() !== $size(e_done)) begin n_err++; $display("FAIL loop_done_count got %0d exp %0d", done_cyc.size(), $size(e_done)); end
    for (int i = 0; i < $size(e_done); i++) begin
      n_cmp++;
      if (i >= done_cyc.size() || done_cyc[i] - t0 !== e_done[i]) begin
        n_err++; $display("FAIL loop_done[%0d] got %0d exp %0d", i, (i < done_cyc.size()) ? done_cyc[i] - t0 : -1, e_done[i]);
      end
    end
    n_done = done_cyc.size();
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL loop_stop_busy got %0h exp 0", busy); end
    step(); step();
    n_cmp++; if (done_cyc.size() !== n_done) begin n_err++; $display("FAIL loop_stop_done got %0d pulses exp %0d", done_cyc.size(), n_done); end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);
    test_reset();
    test_basic();
    test_backpressure();
    test_pace();
    test_zero_length();
    test_stop();
    test_start_stop_idle();
    test_reset_mid_fetch();
    test_loop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
